snoopy_bus_line_controller: RTL and testbench

- Requester-side bus master of the invalidate-protocol snoopy cache. It is the upstream stage that issues BUS_READ, BUS_READ_EXCLUSIVE and BUS_INVALIDATE onto the shared bus; peer snoopy controllers consume those commands.
- On a local miss or upgrade it wins the bus through the arbiter and writes back a dirty victim. It then broadcasts the command, waits for all snoopers, and fills the line word by word into the local cache.
- Sits between the cache's CPU-side protocol logic and the shared bus/arbiter.

---
 rtl/snoopy_bus_line_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_snoopy_bus_line_controller.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoopy_bus_line_controller.sv
// Requester-side bus master for an invalidate-protocol snoopy cache.
// On a local miss or upgrade it arbitrates for the shared bus, writes back a
// dirty victim line, broadcasts the bus command, waits for all peer snoopers
// and then fills the line word by word into the local cache.
//
// Ports:
//   clock, reset           clock and asynchronous active-low reset
//   cpuRequest/cpuCommand  request from the CPU-side protocol logic (level)
//   cpuAddress             missing address (offset field ignored)
//   victimDirty/victimTag  victim writeback control
//   cpuDone                one-cycle completion pulse
//   arbiterRequest/Grant   shared-bus arbitration
//   busCommand/busAddress  command and word address driven onto the bus
//   busRead/busWrite       word strobes (fill / writeback)
//   busDataOut/busDataIn   writeback word out, fill word in
//   busAck                 current word accepted/returned this cycle
//   snoopDone              all peers finished processing busCommand
//   cacheOffset            word offset into the local line
//   cacheDataIn            local word, combinational from cacheOffset
//   cacheDataOut           fill word to the cache
//   cacheWriteData         write cacheDataOut at cacheOffset
//   cacheWriteTag          one-cycle pulse: install tag and new state
module snoopy_bus_line_controller #(
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter int unsigned INDEX_WIDTH  = 4,
    parameter int unsigned TAG_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH   = 16,
    localparam int unsigned ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpuRequest,
    input  logic [1:0]               cpuCommand,
    input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
    input  logic                     victimDirty,
    input  logic [TAG_WIDTH-1:0]     victimTag,
    output logic                     cpuDone,
    output logic                     arbiterRequest,
    input  logic                     arbiterGrant,
    output logic [1:0]               busCommand,
    output logic [ADDRESS_WIDTH-1:0] busAddress,
    output logic                     busRead,
    output logic                     busWrite,
    output logic [DATA_WIDTH-1:0]    busDataOut,
    input  logic [DATA_WIDTH-1:0]    busDataIn,
    input  logic                     busAck,
    input  logic                     snoopDone,
    output logic [OFFSET_WIDTH-1:0]  cacheOffset,
    input  logic [DATA_WIDTH-1:0]    cacheDataIn,
    output logic [DATA_WIDTH-1:0]    cacheDataOut,
    output logic                     cacheWriteData,
    output logic                     cacheWriteTag
);

    localparam logic [1:0] CMD_NONE           = 2'd0;
    localparam logic [1:0] CMD_READ           = 2'd1;
    localparam logic [1:0] CMD_READ_EXCLUSIVE = 2'd2;
    localparam logic [1:0] CMD_INVALIDATE     = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StWbArb,
        StWbXfer,
        StCmdArb,
        StCmdSnoop,
        StFill,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [OFFSET_WIDTH-1:0] counter_q, counter_d;
    logic [1:0]              command_q, command_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [INDEX_WIDTH-1:0]  index_q, index_d;
    logic [TAG_WIDTH-1:0]    victim_tag_q, victim_tag_d;
    // Set for the single CMD_ARB cycle that follows a writeback, during which
    // the bus request is withdrawn so the arbiter can re-arbitrate.
    logic                    rearb_q, rearb_d;

    logic [OFFSET_WIDTH-1:0] counter_inc;
    logic                    counter_last;
    logic                    unused_offset;

    assign counter_inc   = counter_q + OFFSET_WIDTH'(1);
    assign counter_last  = &counter_q;
    assign unused_offset = ^cpuAddress[OFFSET_WIDTH-1:0];

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            counter_q    <= '0;
            command_q    <= CMD_NONE;
            tag_q        <= '0;
            index_q      <= '0;
            victim_tag_q <= '0;
            rearb_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            command_q    <= command_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            victim_tag_q <= victim_tag_d;
            rearb_q      <= rearb_d;
        end
    end

    // Next-state logic. Losing the grant simply stalls every transition that
    // depends on owning the bus, which freezes the word counter in place.
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        command_d    = command_q;
        tag_d        = tag_q;
        index_d      = index_q;
        victim_tag_d = victim_tag_q;
        rearb_d      = rearb_q;

        unique case (state_q)
            StIdle: begin
                if (cpuRequest) begin
                    command_d    = cpuCommand;
                    tag_d        = cpuAddress[ADDRESS_WIDTH-1 -: TAG_WIDTH];
                    index_d      = cpuAddress[OFFSET_WIDTH +: INDEX_WIDTH];
                    victim_tag_d = victimTag;
                    counter_d    = '0;
                    rearb_d      = 1'b0;
                    if (victimDirty && (cpuCommand != CMD_INVALIDATE)) begin
                        state_d = StWbArb;
                    end else begin
                        state_d = StCmdArb;
                    end
                end
            end
            StWbArb: begin
                if (arbiterGrant) begin
                    state_d = StWbXfer;
                end
            end
            StWbXfer: begin
                if (arbiterGrant && busAck) begin
                    counter_d = counter_inc;
                    if (counter_last) begin
                        state_d = StCmdArb;
                        rearb_d = 1'b1;
                    end
                end
            end
            StCmdArb: begin
                if (rearb_q) begin
                    rearb_d = 1'b0;
                end else if (arbiterGrant) begin
                    state_d = StCmdSnoop;
                end
            end
            StCmdSnoop: begin
                // busAck is deliberately ignored here; the first fill word is
                // only requested once in FILL.
                if (arbiterGrant && snoopDone) begin
                    state_d = (command_q == CMD_INVALIDATE) ? StDone : StFill;
                end
            end
            StFill: begin
                if (arbiterGrant && busAck) begin
                    counter_d = counter_inc;
                    if (counter_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        cpuDone        = 1'b0;
        arbiterRequest = 1'b0;
        busCommand     = CMD_NONE;
        busAddress     = '0;
        busRead        = 1'b0;
        busWrite       = 1'b0;
        busDataOut     = '0;
        cacheOffset    = '0;
        cacheDataOut   = '0;
        cacheWriteData = 1'b0;
        cacheWriteTag  = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StWbArb: begin
                arbiterRequest = 1'b1;
            end
            StWbXfer: begin
                arbiterRequest = 1'b1;
                cacheOffset    = counter_q;
                busAddress     = {victim_tag_q, index_q, counter_q};
                if (arbiterGrant) begin
                    busWrite   = 1'b1;
                    busDataOut = cacheDataIn;
                end
            end
            StCmdArb: begin
                arbiterRequest = !rearb_q;
            end
            StCmdSnoop: begin
                arbiterRequest = 1'b1;
                busAddress     = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
                if (arbiterGrant) begin
                    busCommand = command_q;
                end
            end
            StFill: begin
                arbiterRequest = 1'b1;
                cacheOffset    = counter_q;
                busAddress     = {tag_q, index_q, counter_q};
                if (arbiterGrant) begin
                    busCommand = command_q;
                    busRead    = 1'b1;
                    if (busAck) begin
                        cacheWriteData = 1'b1;
                        cacheDataOut   = busDataIn;
                    end
                end
            end
            StDone: begin
                cacheWriteTag = 1'b1;
                cpuDone       = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_snoopy_bus_line_controller.sv
module tb_snoopy_bus_line_controller;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_RD   = 2'd1;
    localparam logic [1:0] CMD_RDX  = 2'd2;
    localparam logic [1:0] CMD_INV  = 2'd3;

    localparam logic [1:0] EV_WR   = 2'd0;
    localparam logic [1:0] EV_RD   = 2'd1;
    localparam logic [1:0] EV_DONE = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  cmd;
    } ev_t;

    logic        clock;
    logic        reset;
    logic        cpuRequest;
    logic [1:0]  cpuCommand;
    logic [15:0] cpuAddress;
    logic        victimDirty;
    logic [7:0]  victimTag;
    logic        cpuDone;
    logic        arbiterRequest;
    logic        arbiterGrant;
    logic [1:0]  busCommand;
    logic [15:0] busAddress;
    logic        busRead;
    logic        busWrite;
    logic [15:0] busDataOut;
    logic [15:0] busDataIn;
    logic        busAck;
    logic        snoopDone;
    logic [3:0]  cacheOffset;
    logic [15:0] cacheDataIn;
    logic [15:0] cacheDataOut;
    logic        cacheWriteData;
    logic        cacheWriteTag;

    logic        grant_en;
    logic        ack_en;
    logic        snoop_phase;
    int          snoop_cnt = 0;
    int          snoop_delay;

    ev_t         exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [1:0]  cur_cmd;
    logic [11:0] cur_line;
    logic        req_seen;
    int          low_cnt;
    int          fills;

    snoopy_bus_line_controller dut (
        .clock          (clock),
        .reset          (reset),
        .cpuRequest     (cpuRequest),
        .cpuCommand     (cpuCommand),
        .cpuAddress     (cpuAddress),
        .victimDirty    (victimDirty),
        .victimTag      (victimTag),
        .cpuDone        (cpuDone),
        .arbiterRequest (arbiterRequest),
        .arbiterGrant   (arbiterGrant),
        .busCommand     (busCommand),
        .busAddress     (busAddress),
        .busRead        (busRead),
        .busWrite       (busWrite),
        .busDataOut     (busDataOut),
        .busDataIn      (busDataIn),
        .busAck         (busAck),
        .snoopDone      (snoopDone),
        .cacheOffset    (cacheOffset),
        .cacheDataIn    (cacheDataIn),
        .cacheDataOut   (cacheDataOut),
        .cacheWriteData (cacheWriteData),
        .cacheWriteTag  (cacheWriteTag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] cache_word(input logic [3:0] off);
        return {4'hC, off, ~off, off};
    endfunction

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        return addr ^ 16'h5A5A;
    endfunction

    // Bench-side arbiter, slave and snoopers.
    assign arbiterGrant = arbiterRequest & grant_en;
    assign busAck       = ack_en;
    assign cacheDataIn  = cache_word(cacheOffset);
    assign busDataIn    = mem_word(busAddress);
    assign snoop_phase  = (busCommand != CMD_NONE) && !busRead;
    assign snoopDone    = snoop_phase && (snoop_cnt >= snoop_delay);

    always @(posedge clock) begin
        snoop_cnt <= snoop_phase ? snoop_cnt + 1 : 0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input logic [1:0] kind, input logic [15:0] addr,
                             input logic [15:0] data, input logic [1:0] cmd);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_event_q_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("ev_kind", kind, e.kind);
            if (kind == e.kind) begin
                check_eq("ev_addr", addr, e.addr);
                check_eq("ev_data", data, e.data);
                check_eq("ev_cmd", cmd, e.cmd);
            end
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every
    // bus handshake and on the completion pulse.
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                if (arbiterRequest) begin
                    req_seen = 1'b1;
                end else if (req_seen && !cpuDone) begin
                    low_cnt++;
                end
                if (snoop_phase) begin
                    check_eq("snoop_cmd", busCommand, cur_cmd);
                    check_eq("snoop_addr", busAddress, {cur_line, 4'h0});
                end
                if (busWrite && busAck) begin
                    pop_check(EV_WR, busAddress, busDataOut, busCommand);
                end
                if (busRead && busAck) begin
                    pop_check(EV_RD, busAddress, cacheDataOut, busCommand);
                    check_eq("fill_we", cacheWriteData, 1'b1);
                    check_eq("fill_off", cacheOffset, busAddress[3:0]);
                    fills++;
                end else if (cacheWriteData) begin
                    check_eq("stray_we", cacheWriteData, 1'b0);
                end
                if (cpuDone || cacheWriteTag) begin
                    pop_check(EV_DONE, 16'h0, 16'h0, busCommand);
                    check_eq("done_tag", {cpuDone, cacheWriteTag}, 2'b11);
                    req_seen = 1'b0;
                end
            end
        end
    end

    task automatic push_events(input logic [1:0] cmd, input logic [15:0] addr,
                               input logic dirty, input logic [7:0] vtag, input int wb_words);
        ev_t e;
        if (dirty && cmd != CMD_INV) begin
            for (int i = 0; i < wb_words; i++) begin
                e.kind = EV_WR;
                e.addr = {vtag, addr[7:4], 4'(i)};
                e.data = cache_word(4'(i));
                e.cmd  = CMD_NONE;
                exp_q.push_back(e);
            end
        end
        if (wb_words == 16) begin
            if (cmd != CMD_INV) begin
                for (int i = 0; i < 16; i++) begin
                    e.kind = EV_RD;
                    e.addr = {addr[15:4], 4'(i)};
                    e.data = mem_word(e.addr);
                    e.cmd  = cmd;
                    exp_q.push_back(e);
                end
            end
            e.kind = EV_DONE;
            e.addr = 16'h0;
            e.data = 16'h0;
            e.cmd  = CMD_NONE;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_op(input logic [1:0] cmd, input logic [15:0] addr, input logic dirty,
                          input logic [7:0] vtag, input int delay, input int exp_gap,
                          input int exp_fills);
        logic done;
        cur_cmd     = cmd;
        cur_line    = addr[15:4];
        snoop_delay = delay;
        low_cnt     = 0;
        req_seen    = 1'b0;
        fills       = 0;
        push_events(cmd, addr, dirty, vtag, 16);
        @(posedge clock);
        #1;
        cpuCommand  = cmd;
        cpuAddress  = addr;
        victimDirty = dirty;
        victimTag   = vtag;
        cpuRequest  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clock);
            #1;
            if (cpuDone) done = 1'b1;
        end
        cpuRequest = 1'b0;
        check_eq("done_seen", done, 1'b1);
        @(negedge clock);
        #1;
        check_eq("q_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check_eq("arb_gap", low_cnt, exp_gap);
        check_eq("fill_count", fills, exp_fills);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctrl"}, {cpuDone, arbiterRequest, busCommand, busRead, busWrite,
                                  cacheOffset, cacheWriteData, cacheWriteTag}, 32'd0);
        check_eq({tag, "_addr"}, busAddress, 32'd0);
        check_eq({tag, "_data"}, {busDataOut, cacheDataOut}, 32'd0);
    endtask

    initial begin
        logic found;
        reset       = 1'b0;
        cpuRequest  = 1'b0;
        cpuCommand  = CMD_NONE;
        cpuAddress  = 16'h0;
        victimDirty = 1'b0;
        victimTag   = 8'h0;
        grant_en    = 1'b1;
        ack_en      = 1'b1;
        snoop_delay = 0;
        cur_cmd     = CMD_NONE;
        cur_line    = 12'h0;
        req_seen    = 1'b0;
        low_cnt     = 0;
        fills       = 0;
        #1;
        check_outputs_zero("reset_state");
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        // Clean read, snoopers finish after 2 cycles.
        run_op(CMD_RD, 16'h03A5, 1'b0, 8'h00, 2, 0, 16);

        // Dirty read-exclusive: writeback, one-cycle request gap, then fill.
        run_op(CMD_RDX, 16'h2245, 1'b1, 8'h11, 1, 1, 16);

        // Invalidate ignores victimDirty: no writeback, no fill.
        run_op(CMD_INV, 16'h5670, 1'b1, 8'h33, 3, 0, 0);

        // Grant withdrawn for 3 cycles at fill word 7.
        fork
            run_op(CMD_RD, 16'h7B30, 1'b0, 8'h00, 1, 0, 16);
            begin
                found = 1'b0;
                for (int i = 0; i < 200 && !found; i++) begin
                    @(posedge clock);
                    #1;
                    if (busRead && cacheOffset == 4'd7) found = 1'b1;
                end
                check_eq("fill7_seen", found, 1'b1);
                grant_en = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clock);
                    check_eq("stall_strobes", {busRead, busWrite, cacheWriteData}, 3'b000);
                    check_eq("stall_offset", cacheOffset, 4'd7);
                    check_eq("stall_req", arbiterRequest, 1'b1);
                    if (i < 2) @(posedge clock);
                end
                @(posedge clock);
                #1;
                grant_en = 1'b1;
            end
        join

        // Reset pulled during writeback word 5.
        cur_cmd  = CMD_RDX;
        cur_line = 12'h224;
        push_events(CMD_RDX, 16'h2245, 1'b1, 8'h11, 5);
        @(posedge clock);
        #1;
        cpuCommand  = CMD_RDX;
        cpuAddress  = 16'h2245;
        victimDirty = 1'b1;
        victimTag   = 8'h11;
        cpuRequest  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clock);
            #1;
            if (busWrite && cacheOffset == 4'd5) found = 1'b1;
        end
        check_eq("wb5_seen", found, 1'b1);
        reset      = 1'b0;
        cpuRequest = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        check_eq("mid_reset_q", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        run_op(CMD_RD, 16'h9C00, 1'b1, 8'h42, 2, 1, 16);

        // snoopDone coincides with busAck on the first snoop cycle.
        run_op(CMD_RDX, 16'h4A1F, 1'b0, 8'h00, 0, 0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
